// File: rtl/dac_pkg.sv
// Shared definitions for the DAC sample source and the serial DAC driver.
package dac_pkg;

  // Clocks per DAC frame; the driver uses the same value so both counters stay aligned.
  localparam int FRAME_LEN_DEF = 20;
  localparam int PHASE_W_DEF   = 24;

  // Waveform selector encodings.
  localparam logic [1:0] WAVE_SINE = 2'd0;
  localparam logic [1:0] WAVE_TRI  = 2'd1;
  localparam logic [1:0] WAVE_SAW  = 2'd2;
  localparam logic [1:0] WAVE_SQR  = 2'd3;

  // Generator control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Clamp a 9-bit sum into the 8-bit DAC range.
  function automatic logic [7:0] sat9(input logic [8:0] sum);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/dac_sine_rom.sv
// Quarter-wave sine lookup with a registered output. The 8-bit phase selects a
// quadrant (top two bits) and a 64-entry table index; the table holds
// round(127*sin(pi/2*(i+0.5)/64)) so the waveform is symmetric about 127.5.
module dac_sine_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_phase,
  output logic [7:0] o_sine
);

  localparam logic [6:0] QTAB [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [5:0] w_addr;
  logic [6:0] w_q;
  logic [7:0] w_sine;
  logic [7:0] r_sine;

  // Odd quadrants walk the table backwards (63-idx == ~idx); upper half is mirrored below mid-scale.
  assign w_addr = i_phase[6] ? ~i_phase[5:0] : i_phase[5:0];
  assign w_q    = QTAB[w_addr];
  assign w_sine = i_phase[7] ? (8'd127 - {1'b0, w_q}) : (8'd128 + {1'b0, w_q});

  // Registered lookup, updated only on the pipeline stage that consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sine <= 8'd0;
    end else if (i_en) begin
      r_sine <= w_sine;
    end
  end

  assign o_sine = r_sine;

endmodule

// File: rtl/dac_wave_gen.sv
// DDS waveform source feeding the serial DAC driver. One sample is computed per
// frame through a short pipeline (cnt 0..2) and committed at the last frame
// clock, so DAC_Data changes exactly when the driver starts a new frame.
// FRAME_LEN must be at least 4 so the pipeline finishes before the commit.
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PHASE_W   = PHASE_W_DEF
) (
  input  logic               clk_DAC,
  input  logic               rst,
  input  logic               gen_en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         amp,
  input  logic [7:0]         offset,
  output logic [7:0]         DAC_Data,
  output logic               DAC_En,
  output logic               sample_tick,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic [7:0]         r_p;
  logic [1:0]         r_wave_s;
  logic [7:0]         r_amp_s;
  logic [7:0]         r_off_s;
  logic [7:0]         r_raw;
  logic [7:0]         r_scaled;
  logic [7:0]         r_dac_data;
  logic               r_dac_en;
  logic               r_tick;

  logic               w_active;
  logic               w_frame_end;
  logic               w_commit;
  logic               w_stage0;
  logic               w_stage1;
  logic               w_stage2;
  logic [7:0]         w_sine;
  logic [7:0]         w_raw;
  logic [15:0]        w_prod;
  logic [8:0]         w_sum;

  assign w_active    = (r_state != IDLE);
  assign w_frame_end = (r_cnt == CNT_LAST);
  assign w_commit    = w_active && w_frame_end;
  assign w_stage0    = w_active && (r_cnt == '0);
  assign w_stage1    = w_active && (r_cnt == CNT_ONE);
  assign w_stage2    = w_active && (r_cnt == CNT_TWO);

  // State register.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leaving RUN is only decided at a frame boundary to keep the driver aligned.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (gen_en) w_state_next = PRIME;
      PRIME:   if (w_frame_end) w_state_next = RUN;
      RUN:     if (w_frame_end && !gen_en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Frame counter: free-runs 0..FRAME_LEN-1 while active, parked at 0 in IDLE.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!w_active || w_frame_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Phase accumulator and per-frame shadow of the control inputs.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_phase  <= '0;
      r_p      <= 8'd0;
      r_wave_s <= 2'd0;
      r_amp_s  <= 8'd0;
      r_off_s  <= 8'd0;
    end else if (r_state == IDLE) begin
      if (gen_en) r_phase <= '0;
    end else if (w_stage0) begin
      r_phase  <= r_phase + freq_word;
      r_p      <= r_phase[PHASE_W-1 -: 8];
      r_wave_s <= wave_sel;
      r_amp_s  <= amp;
      r_off_s  <= offset;
    end
  end

  // Arithmetic waveforms; sine comes from the ROM, which registers on the same stage.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_raw <= 8'd0;
    end else if (w_stage1) begin
      case (r_wave_s)
        WAVE_TRI: r_raw <= r_p[7] ? ~{r_p[6:0], 1'b0} : {r_p[6:0], 1'b0};
        WAVE_SQR: r_raw <= r_p[7] ? 8'h00 : 8'hFF;
        default:  r_raw <= r_p;
      endcase
    end
  end

  dac_sine_rom u_sine_rom (
    .clk     (clk_DAC),
    .rst     (rst),
    .i_en    (w_stage1),
    .i_phase (r_p),
    .o_sine  (w_sine)
  );

  assign w_raw  = (r_wave_s == WAVE_SINE) ? w_sine : r_raw;
  assign w_prod = 16'(w_raw) * 16'({1'b0, r_amp_s} + 9'd1);
  assign w_sum  = 9'(w_prod >> 8) + {1'b0, r_off_s};

  // Gain and offset stage with saturation at full scale.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_scaled <= 8'd0;
    end else if (w_stage2) begin
      r_scaled <= sat9(w_sum);
    end
  end

  // Commit to the driver at the frame boundary; enable follows the RUN state.
  always_ff @(posedge clk_DAC or posedge rst) begin
    if (rst) begin
      r_dac_data <= 8'd0;
      r_dac_en   <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick   <= w_commit;
      r_dac_en <= (w_state_next == RUN);
      if (w_commit) r_dac_data <= r_scaled;
    end
  end

  assign DAC_Data    = r_dac_data;
  assign DAC_En      = r_dac_en;
  assign sample_tick = r_tick;
  assign busy        = w_active;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Self-checking bench for dac_wave_gen: directed scenarios plus randomized
// frames, compared against a sample model built from the waveform formulas.
module tb_dac_wave_gen;

  localparam int FL = 20;

  typedef struct {
    logic [23:0] f;
    logic [1:0]  w;
    logic [7:0]  a;
    logic [7:0]  o;
  } set_t;

  logic        clk_DAC;
  logic        rst;
  logic        gen_en;
  logic [23:0] freq_word;
  logic [1:0]  wave_sel;
  logic [7:0]  amp;
  logic [7:0]  offset;
  logic [7:0]  DAC_Data;
  logic        DAC_En;
  logic        sample_tick;
  logic        busy;

  int          n_cmp;
  int          n_bad;
  int          n_frame;
  set_t        cur;
  logic [23:0] ph_m;
  logic [7:0]  last_data;

  dac_wave_gen dut (
    .clk_DAC     (clk_DAC),
    .rst         (rst),
    .gen_en      (gen_en),
    .freq_word   (freq_word),
    .wave_sel    (wave_sel),
    .amp         (amp),
    .offset      (offset),
    .DAC_Data    (DAC_Data),
    .DAC_En      (DAC_En),
    .sample_tick (sample_tick),
    .busy        (busy)
  );

  initial clk_DAC = 1'b0;
  always #5 clk_DAC = ~clk_DAC;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Quarter-wave amplitude straight from the sine formula.
  function automatic int qv(input int i);
    return $rtoi(127.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / 128.0) + 0.5);
  endfunction

  // Expected committed sample for a frame starting at phase ph with settings s.
  function automatic int model(input logic [23:0] ph, input set_t s);
    int p, quad, idx, raw, sum;
    p    = int'(ph[23:16]);
    quad = p / 64;
    idx  = p % 64;
    case (s.w)
      2'd0: begin
        if (quad == 0)      raw = 128 + qv(idx);
        else if (quad == 1) raw = 128 + qv(63 - idx);
        else if (quad == 2) raw = 127 - qv(idx);
        else                raw = 127 - qv(63 - idx);
      end
      2'd1:    raw = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      2'd2:    raw = p;
      default: raw = (p < 128) ? 255 : 0;
    endcase
    sum = (raw * (int'(s.a) + 1)) / 256 + int'(s.o);
    return (sum > 255) ? 255 : sum;
  endfunction

  function automatic set_t rand_set();
    set_t s;
    s.f = 24'($urandom);
    s.w = 2'($urandom);
    s.a = 8'($urandom);
    s.o = 8'($urandom_range(0, 120));
    return s;
  endfunction

  task automatic drive(input set_t s);
    freq_word = s.f;
    wave_sel  = s.w;
    amp       = s.a;
    offset    = s.o;
  endtask

  // Called just after a clock edge with the block in IDLE; gen_en is sampled on the next edge.
  task automatic start(input set_t s);
    drive(s);
    cur    = s;
    ph_m   = '0;
    gen_en = 1'b1;
    @(posedge clk_DAC); #1;
    check("prime_busy", busy, 1);
    check("prime_en", DAC_En, 0);
  endtask

  // One full frame; next-frame settings are applied mid-frame (after cnt=4).
  task automatic frame(input set_t nxt, input bit drop, input bit en_mid);
    int ticks, en_bad, data_bad, expv;
    ticks = 0; en_bad = 0; data_bad = 0;
    for (int c = 0; c < FL; c++) begin
      @(posedge clk_DAC); #1;
      if (sample_tick === 1'b1) ticks++;
      if (c < FL - 1) begin
        if (DAC_En !== en_mid) en_bad++;
        if (DAC_Data !== last_data) data_bad++;
      end
      if (c == 4) drive(nxt);
      if (c == 6 && drop) gen_en = 1'b0;
    end
    expv = model(ph_m, cur);
    check("data", DAC_Data, expv);
    check("tick_at_commit", sample_tick, 1);
    check("ticks_per_frame", ticks, 1);
    check("en_during_frame", en_bad, 0);
    check("data_hold", data_bad, 0);
    check("en_after_commit", DAC_En, !drop);
    $display("frame %0d wave=%0d amp=%0d off=%0d p=%0d data=%0d exp=%0d en=%0d",
             n_frame, cur.w, cur.a, cur.o, ph_m[23:16], DAC_Data, expv, DAC_En);
    n_frame++;
    last_data = expv[7:0];
    ph_m      = ph_m + cur.f;
    cur       = nxt;
  endtask

  initial begin
    set_t s_saw, s_sqr, s_a, s_b, s_c, s_sin, s_sat, s_r;
    n_cmp = 0; n_bad = 0; n_frame = 0;
    last_data = 8'd0;
    rst = 1'b1; gen_en = 1'b0;
    freq_word = '0; wave_sel = '0; amp = '0; offset = '0;

    // Reset state
    repeat (3) @(posedge clk_DAC);
    #1;
    check("rst_data", DAC_Data, 0);
    check("rst_en", DAC_En, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk_DAC); #1;

    // Sawtooth ramp, then square at quarter-cycle steps
    s_saw = '{f: 24'h010000, w: 2'd2, a: 8'd255, o: 8'd0};
    s_sqr = '{f: 24'h400000, w: 2'd3, a: 8'd255, o: 8'd0};
    start(s_saw);
    frame(s_saw, 0, 0);
    frame(s_saw, 0, 1);
    frame(s_saw, 0, 1);
    frame(s_sqr, 0, 1);
    repeat (5) frame(s_sqr, 0, 1);

    // Randomized frames with mid-frame setting changes
    repeat (20) frame(rand_set(), 0, 1);

    // gen_en dropped mid-frame: the frame completes, then the block idles
    frame(rand_set(), 1, 1);
    check("busy_after_disable", busy, 0);

    // Shadow latch: amp change mid-frame only affects the next sample (200 -> 100)
    s_a = '{f: 24'hC80000, w: 2'd2, a: 8'd255, o: 8'd0};
    s_b = '{f: 24'h000000, w: 2'd2, a: 8'd255, o: 8'd0};
    s_c = '{f: 24'h000000, w: 2'd2, a: 8'd127, o: 8'd0};
    start(s_a);
    frame(s_b, 0, 0);
    frame(s_c, 0, 1);
    frame(s_c, 1, 1);

    // Sine restart at phase 0, then random frames with a non-zero floor
    s_sin = '{f: 24'h030000, w: 2'd0, a: 8'd255, o: 8'd0};
    start(s_sin);
    frame(s_sin, 0, 0);
    for (int k = 0; k < 10; k++) begin
      s_r   = rand_set();
      s_r.o = 8'($urandom_range(50, 255));
      frame(s_r, 0, 1);
    end

    // Asynchronous reset mid-frame
    repeat (7) @(posedge clk_DAC);
    #3 rst = 1'b1;
    #1;
    check("async_rst_data", DAC_Data, 0);
    check("async_rst_en", DAC_En, 0);
    check("async_rst_tick", sample_tick, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk_DAC); #1;
    rst = 1'b0;
    last_data = 8'd0;

    // Restart after reset: phase 0, then saturation at p=255 with offset 200
    s_sat = '{f: 24'hFF0000, w: 2'd2, a: 8'd255, o: 8'd200};
    start(s_sat);
    frame(s_sat, 0, 0);
    frame(rand_set(), 0, 1);
    repeat (5) frame(rand_set(), 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
Sample source that sits directly upstream of the team's 8-bit serial DAC driver. It produces the driver's `DAC_Data` and `DAC_En` inputs.
- A DDS phase accumulator selects one of four waveforms: sine, triangle, sawtooth or square.
- The raw sample is scaled by an amplitude gain and shifted by an offset.
- One new sample is committed per DAC frame. The internal frame counter is kept lock-step with the driver's frame counter.

Parameters:
- FRAME_LEN, 20, clocks per DAC frame; must equal the driver's frame length; must be ≥ 4.
- PHASE_W, 24, phase accumulator width; the top 8 bits address the waveform.

Ports:
- clk_DAC  in  1  DAC bit clock, shared with the driver.
- rst  in  1  asynchronous, active-high reset.
- gen_en  in  1  generator enable request.
- freq_word  in  PHASE_W  phase increment applied per frame.
- wave_sel  in  2  waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- amp  in  8  gain; effective gain is (amp+1)/256.
- offset  in  8  added after scaling.
- DAC_Data  out  8  sample to the driver; held stable for a whole frame.
- DAC_En  out  1  driver enable.
- sample_tick  out  1  one-cycle pulse on each sample commit.
- busy  out  1  high in PRIME or RUN.

Behaviour:
- Reset values: DAC_Data=0, DAC_En=0, sample_tick=0, busy=0, cnt=0, phase=0, state=IDLE, shadow registers=0.
- Frame counter cnt:
  - counts 0..FRAME_LEN-1 and wraps to 0;
  - runs only in PRIME and RUN;
  - is held at 0 in IDLE.
- IDLE state:
  - DAC_En=0, cnt=0.
  - gen_en=1 → go to PRIME, clear phase to 0.
- PRIME state: runs one full frame with DAC_En still 0, so the first sample is computed before the driver starts.
  - At cnt=FRAME_LEN-1: commit the sample, pulse sample_tick, set DAC_En=1, go to RUN.
  - The driver's counter and cnt are therefore both 0 on the first enabled edge.
- RUN state: commit a new sample at every cnt=FRAME_LEN-1.
  - If gen_en=0 at that edge, DAC_En goes to 0 and the state returns to IDLE. The sample is still committed and sample_tick still pulses.
  - gen_en=0 at any other cnt is ignored until the frame end. Disabling mid-frame is never allowed, because the driver freezes its counter when disabled and would lose alignment.
- Pipeline per frame:
  - cnt=0: latch freq_word, wave_sel, amp and offset into the shadow registers; capture p = phase[PHASE_W-1:PHASE_W-8]; phase <= phase + freq_word (modulo 2^PHASE_W, wraps silently).
  - cnt=1: raw sample registered from p and the shadow wave_sel.
  - cnt=2: scaled sample registered: ((raw*(amp_s+1))>>8) + offset_s, saturated to 255. Use a 9-bit sum.
  - cnt=FRAME_LEN-1: DAC_Data <= scaled sample.
  - Input changes mid-frame take effect only from the next frame's cnt=0.
- Waveforms, with p the 8-bit phase:
  - Sawtooth: raw = p.
  - Square: raw = 255 if p<128, else 0.
  - Triangle: raw = {p[6:0],0} if p[7]=0, else ~{p[6:0],0}.
  - Sine: quarter-wave ROM q[i] = round(127·sin(π/2·(i+0.5)/64)), i=0..63, with idx = p[5:0]. By quadrant p[7:6]:
    - 0: 128+q[idx]
    - 1: 128+q[63-idx]
    - 2: 127-q[idx]
    - 3: 127-q[63-idx]
- gen_en re-asserted in IDLE: restarts PRIME with phase=0, so the waveform restarts deterministically.
- rst asserted mid-frame: the block returns to IDLE immediately. The driver has no reset, so system rst is only permitted at power-up or while DAC_En=0.
- Latency: the first DAC_Data is valid FRAME_LEN clocks after gen_en is sampled in IDLE. Thereafter one sample per FRAME_LEN clocks.

Decomposition:
- Shared package dac_pkg holds:
  - the FRAME_LEN default (shared with the driver);
  - the wave_sel encodings: WAVE_SINE=0, WAVE_TRI=1, WAVE_SAW=2, WAVE_SQR=3;
  - the state encoding: IDLE, PRIME, RUN.
- One sub-module, dac_sine_rom:
  - registered quarter-wave lookup;
  - 8-bit phase in, 8-bit sine out;
  - 1-clock latency, aligned with the cnt=1 stage.

Test Plan:
- Sawtooth ramp: wave_sel=2, amp=255, offset=0, freq_word=1<<(PHASE_W-8), gen_en=1 → DAC_Data = 0,1,2,… one step per frame; DAC_En rises exactly 20 clocks after gen_en; sample_tick every 20 clocks.
- Square: wave_sel=3, amp=255, freq_word=1<<(PHASE_W-2) → DAC_Data sequence 255,255,0,0,… repeating.
- Sine start and saturation:
  - wave_sel=0, amp=255, offset=0 → first sample 130 (q[0]=2);
  - wave_sel=2, amp=255, offset=200, p=255 → DAC_Data saturates at 255.
- Mid-frame disable: drop gen_en at cnt=7 → DAC_En stays 1 until the cnt=19 edge, then goes 0 with cnt=0; the driver output shows a complete frame.
- Shadow latch: change amp from 255 to 127 at cnt=5 → the current frame's sample is unaffected; the next committed sample is halved (raw 200 → 100).
- Reset: assert rst asynchronously in RUN → all outputs 0 immediately; after release, gen_en=1 re-primes with phase=0.
